uart_rx_fifo: RTL and testbench

//   Receive buffer downstream of the UART receiver. Captures each completed rx byte on a one-cycle strobe.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_fifo_mem.sv | 40 ++++
 rtl/uart_rx_fifo.sv | 144 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and helpers for the receive path.
//               Provides default character width and oversampling rate,
//               the on-wire character length, and the idle-timeout tick
//               count helper used by uart_rx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Default character width and baud oversampling factor.
  localparam int UART_D_W       = 8;
  localparam int UART_B_TICK    = 16;

  // One character on the wire: start + 8 data + stop.
  localparam int UART_CHAR_BITS = 10;

  // Number of baud_clk ticks that make up an idle timeout of to_chars
  // character times.
  function automatic int uart_timeout_ticks(input int to_chars, input int b_tick);
    return to_chars * UART_CHAR_BITS * b_tick;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_mem
// Description : DEPTH x D_W register array backing the receive buffer.
//               Synchronous write, asynchronous (combinational) read so the
//               head entry falls through to the output without a bubble.
// Ports       : clk    - system clock
//               we     - write enable
//               waddr  - write address
//               wdata  - write data
//               raddr  - read address
//               rdata  - read data (combinational from raddr)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int D_W   = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [D_W-1:0]           wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [D_W-1:0]           rdata
);

  // Contents are intentionally not reset; validity is tracked by the
  // level counter in the parent.
  logic [D_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : uart_rx_fifo_mem
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive buffer downstream of the UART receiver. Captures
//               each completed byte on a one-cycle strobe into a circular
//               buffer presented first-word-fall-through. Flags a sticky
//               overrun when a byte is dropped while full. Optional idle
//               timeout, enabled by defining UART_RX_FIFO_TIMEOUT_EN, flags
//               bytes left sitting in the buffer for TO_CHARS characters.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               wr_data/valid - byte strobe from the receiver
//               baud_clk      - oversampling tick (timeout build only)
//               rd_data/valid/ready - FWFT consumer handshake
//               level, full   - occupancy
//               overrun, clr_overrun - sticky drop flag and its clear
//               timeout       - idle timeout flag (0 when compiled out)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int D_W      = UART_D_W,
  parameter int DEPTH    = 16,
  parameter int B_TICK   = UART_B_TICK,
  parameter int TO_CHARS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [D_W-1:0]           wr_data,
  input  logic                     wr_valid,
  input  logic                     baud_clk,
  output logic [D_W-1:0]           rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overrun,
  input  logic                     clr_overrun,
  output logic                     timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] c_DEPTH_L = LW'(DEPTH);
  localparam int C_TO_TICKS = uart_timeout_ticks(TO_CHARS, B_TICK);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overrun;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;

  assign rd_valid = (r_level != '0);
  assign full     = (r_level == c_DEPTH_L);
  assign level    = r_level;
  assign overrun  = r_overrun;

  // A pop frees a slot on the same edge, so a full buffer still accepts a
  // byte when the consumer is reading.
  assign w_pop  = rd_valid && rd_ready;
  assign w_push = wr_valid && (!full || w_pop);
  assign w_drop = wr_valid && !w_push;

  uart_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .D_W   (D_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (wr_data),
    .raddr (r_rd_ptr),
    .rdata (rd_data)
  );

  // Pointers wrap by natural overflow since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins, so no lost byte goes unseen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int CW = $clog2(C_TO_TICKS + 1);
  localparam logic [CW-1:0] c_TO_LAST = CW'(C_TO_TICKS - 1);

  logic [CW-1:0] r_to_cnt;
  logic          r_timeout;

  // Count idle baud ticks while data sits unread; any traffic restarts
  // the window. Counting pauses once the flag is raised.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (w_push || w_pop) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (r_level == '0) begin
      r_to_cnt  <= '0;
    end else if (baud_clk && !r_timeout) begin
      if (r_to_cnt == c_TO_LAST) begin
        r_timeout <= 1'b1;
        r_to_cnt  <= '0;
      end else begin
        r_to_cnt  <= r_to_cnt + CW'(1);
      end
    end
  end

  assign timeout = r_timeout;
`else
  // Timeout feature compiled out: baud_clk and the timing parameters are
  // intentionally unused.
  logic w_unused_cfg;
  assign w_unused_cfg = baud_clk ^ (C_TO_TICKS == 0);
  assign timeout      = 1'b0;
`endif

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo. A queue-based model
//               tracks expected contents, overrun and timeout; every cycle
//               the DUT outputs are compared against it. Directed scenarios
//               pin the model with literal expectations, then a randomized
//               phase exercises mixed traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int D_W   = 8;
  localparam int DEPTH = 16;
  localparam int TICKS = 4 * 10 * 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [D_W-1:0] wr_data = '0;
  logic           wr_valid = 1'b0;
  logic           baud_clk = 1'b0;
  logic [D_W-1:0] rd_data;
  logic           rd_valid;
  logic           rd_ready = 1'b0;
  logic [4:0]     level;
  logic           full;
  logic           overrun;
  logic           clr_overrun = 1'b0;
  logic           timeout;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(
    .D_W      (D_W),
    .DEPTH    (DEPTH),
    .B_TICK   (16),
    .TO_CHARS (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .baud_clk    (baud_clk),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .level       (level),
    .full        (full),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [D_W-1:0] m_q[$];
  bit             m_ovr = 0;
  bit             m_to  = 0;
  int             m_idle = 0;
  bit             started = 0;

  always @(posedge clk) begin
    bit p_pop, p_push;
    started = 1;
    if (rst) begin
      m_q.delete();
      m_ovr  = 0;
      m_to   = 0;
      m_idle = 0;
    end else begin
      p_pop  = (m_q.size() > 0) && rd_ready;
      p_push = wr_valid && ((m_q.size() < DEPTH) || p_pop);
      if (wr_valid && !p_push) m_ovr = 1;
      else if (clr_overrun)    m_ovr = 0;
`ifdef UART_RX_FIFO_TIMEOUT_EN
      if (p_push || p_pop) begin
        m_idle = 0;
        m_to   = 0;
      end else if (m_q.size() == 0) begin
        m_idle = 0;
      end else if (baud_clk && !m_to) begin
        m_idle++;
        if (m_idle == TICKS) begin
          m_to   = 1;
          m_idle = 0;
        end
      end
`endif
      if (p_pop)  void'(m_q.pop_front());
      if (p_push) m_q.push_back(wr_data);
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("rd_valid", {31'b0, rd_valid}, {31'b0, m_q.size() != 0});
      if (m_q.size() != 0) chk("rd_data", {24'b0, rd_data}, {24'b0, m_q[0]});
      chk("level", {27'b0, level}, m_q.size());
      chk("full", {31'b0, full}, {31'b0, m_q.size() == DEPTH});
      chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
      chk("timeout", {31'b0, timeout}, {31'b0, m_to});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wr_valid = 0; rd_ready = 0; clr_overrun = 0; baud_clk = 0; rst = 0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_valid = 1; wr_data = b; step(); wr_valid = 0;
  endtask

  initial begin
    int ticks;
    rst = 1;
    step(); step();
    // Reset state
    chk("rst_level", {27'b0, level}, 0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 0);
    chk("rst_full", {31'b0, full}, 0);
    chk("rst_overrun", {31'b0, overrun}, 0);
    chk("rst_timeout", {31'b0, timeout}, 0);
    idle_inputs();
    step();

    // 1: single byte through
    push_byte(8'hA5);
    chk("t1_valid", {31'b0, rd_valid}, 1);
    chk("t1_data", {24'b0, rd_data}, 32'hA5);
    chk("t1_level", {27'b0, level}, 1);
    rd_ready = 1; step(); rd_ready = 0;
    chk("t1_empty", {31'b0, rd_valid}, 0);
    chk("t1_level0", {27'b0, level}, 0);

    // 2: fill and drain in order with pointer wrap
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("t2_full", {31'b0, full}, 1);
    chk("t2_level", {27'b0, level}, 16);
    chk("t2_ovr", {31'b0, overrun}, 0);
    for (int i = 0; i < 16; i++) begin
      chk("t2_order", {24'b0, rd_data}, i);
      rd_ready = 1; step(); rd_ready = 0;
    end
    chk("t2_drained", {27'b0, level}, 0);

    // 3: overrun set/clear, set beats clear
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
    push_byte(8'hEE);
    chk("t3_ovr", {31'b0, overrun}, 1);
    chk("t3_level", {27'b0, level}, 16);
    clr_overrun = 1; step(); clr_overrun = 0;
    chk("t3_clr", {31'b0, overrun}, 0);
    clr_overrun = 1; push_byte(8'hEE); clr_overrun = 0;
    chk("t3_set_wins", {31'b0, overrun}, 1);
    clr_overrun = 1; step(); clr_overrun = 0;
    for (int i = 0; i < 16; i++) begin
      chk("t3_no_ee", {24'b0, rd_data}, 32'h10 + i);
      rd_ready = 1; step(); rd_ready = 0;
    end

    // 4: push+pop while full, and at empty
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
    rd_ready = 1; push_byte(8'h77); rd_ready = 0;
    chk("t4_level", {27'b0, level}, 16);
    chk("t4_ovr", {31'b0, overrun}, 0);
    for (int i = 1; i < 16; i++) begin
      chk("t4_order", {24'b0, rd_data}, 32'h20 + i);
      rd_ready = 1; step(); rd_ready = 0;
    end
    chk("t4_last", {24'b0, rd_data}, 32'h77);
    rd_ready = 1; step(); rd_ready = 0;
    rd_ready = 1; push_byte(8'h78); rd_ready = 0;
    chk("t4_empty_push", {27'b0, level}, 1);
    chk("t4_empty_data", {24'b0, rd_data}, 32'h78);
    rd_ready = 1; step(); rd_ready = 0;

    // 5: reset mid-drain
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    rd_ready = 1; step();
    rst = 1; step(); rst = 0; rd_ready = 0;
    chk("t5_level", {27'b0, level}, 0);
    chk("t5_valid", {31'b0, rd_valid}, 0);
    chk("t5_ovr", {31'b0, overrun}, 0);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    // 6: idle timeout after exactly 640 ticks
    push_byte(8'h55);
    ticks = 0;
    while (ticks < TICKS - 1) begin
      baud_clk = 1; step(); baud_clk = 0; step();
      ticks++;
    end
    chk("t6_not_yet", {31'b0, timeout}, 0);
    baud_clk = 1; step(); baud_clk = 0;
    chk("t6_fired", {31'b0, timeout}, 1);
    rd_ready = 1; step(); rd_ready = 0;
    chk("t6_cleared", {31'b0, timeout}, 0);
`else
    ticks = 0;
    baud_clk = 1; push_byte(8'h55);
    for (int i = 0; i < 50; i++) step();
    baud_clk = 0;
    chk("t6_tied_off", {31'b0, timeout}, ticks);
    rd_ready = 1; step(); rd_ready = 0;
`endif

    // Randomized traffic, with phases of slow and fast consumers
    for (int n = 0; n < 6000; n++) begin
      int rd_pct;
      rd_pct      = ((n / 1000) % 2 == 0) ? 30 : 80;
      wr_valid    = ($urandom_range(99) < 50);
      wr_data     = 8'($urandom);
      rd_ready    = ($urandom_range(99) < rd_pct);
      clr_overrun = ($urandom_range(99) < 5);
      baud_clk    = ($urandom_range(99) < 90);
      rst         = ($urandom_range(999) < 2);
      step();
    end
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: time limit expired, expected finish before %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx_fifo
`default_nettype wire
